// File: rtl/regfile_pkg.sv
// Shared condition-code encodings and the CC derivation helper for regfile_mp.
package regfile_pkg;

  localparam logic [2:0] CC_N     = 3'b100;
  localparam logic [2:0] CC_Z     = 3'b010;
  localparam logic [2:0] CC_P     = 3'b001;
  localparam logic [2:0] CC_RESET = CC_Z;

  // Takes sign and zero flags so it works for any data width.
  function automatic logic [2:0] cc_of(input logic sign, input logic is_zero);
    if (sign)
      return CC_N;
    else if (is_zero)
      return CC_Z;
    else
      return CC_P;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets a bit, write-back clears it, set wins on collision.
module regfile_scoreboard #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy,
  output logic             any_busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  // Addresses >= DEPTH match no bit, so out-of-range strobes fall through.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic w_set;
      logic w_clr;
      assign w_set = set_en && (set_addr == AW'(gi));
      assign w_clr = clr_en && (clr_addr == AW'(gi));
      assign w_busy_next[gi] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_)
      r_busy <= '0;
    else
      r_busy <= w_busy_next;
  end

  assign busy     = r_busy;
  assign any_busy = |r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and N/Z/P condition codes.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_cc_en,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [2:0]           cc,
  output logic                 any_busy
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [2:0]       r_cc;
  logic [DEPTH-1:0] w_busy;
  logic             w_wr_in_range;

  assign w_wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
      r_cc <= CC_RESET;
    end else if (wr_en && w_wr_in_range) begin
      r_regs[wr_addr] <= wr_data;
      if (wr_cc_en)
        r_cc <= cc_of(wr_data[WIDTH-1], wr_data == '0);
    end
  end

  assign cc = r_cc;

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset_   (reset_),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .busy     (w_busy),
    .any_busy (any_busy)
  );

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]    w_addr;
      logic             w_in_range;
      logic [WIDTH-1:0] w_data;
      logic             w_busy_bit;

      assign w_addr     = rd_addr[gi*AW +: AW];
      assign w_in_range = ({1'b0, w_addr} < (AW+1)'(DEPTH));

      always_comb begin
        w_data     = '0;
        w_busy_bit = 1'b0;
        if (w_in_range) begin
`ifdef REGFILE_BYPASS_EN
          if (wr_en && (wr_addr == w_addr)) begin
            w_data     = wr_data;
            w_busy_bit = iss_en && (iss_addr == w_addr);
          end else begin
            w_data     = r_regs[w_addr];
            w_busy_bit = w_busy[w_addr];
          end
`else
          w_data     = r_regs[w_addr];
          w_busy_bit = w_busy[w_addr];
`endif
        end
      end

      assign rd_data[gi*WIDTH +: WIDTH] = w_data;
      assign rd_busy[gi]                = w_busy_bit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 8x2 and a 6-deep, 3-port instance).
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_;
  int          checks   = 0;
  int          failures = 0;

  // Instance A: WIDTH=16, DEPTH=8, NRD=2
  logic        a_wr_en, a_wr_cc_en, a_iss_en;
  logic [2:0]  a_wr_addr, a_iss_addr;
  logic [15:0] a_wr_data;
  logic [5:0]  a_rd_addr;
  logic [31:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [2:0]  a_cc;
  logic        a_any_busy;

  // Instance B: WIDTH=16, DEPTH=6, NRD=3
  logic        b_wr_en, b_wr_cc_en, b_iss_en;
  logic [2:0]  b_wr_addr, b_iss_addr;
  logic [15:0] b_wr_data;
  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic [2:0]  b_cc;
  logic        b_any_busy;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_mp u_dut_a (
    .clk      (clk),
    .reset_   (reset_),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_data  (a_wr_data),
    .wr_cc_en (a_wr_cc_en),
    .iss_en   (a_iss_en),
    .iss_addr (a_iss_addr),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .rd_busy  (a_rd_busy),
    .cc       (a_cc),
    .any_busy (a_any_busy)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(6), .NRD(3)) u_dut_b (
    .clk      (clk),
    .reset_   (reset_),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .wr_cc_en (b_wr_cc_en),
    .iss_en   (b_iss_en),
    .iss_addr (b_iss_addr),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_busy  (b_rd_busy),
    .cc       (b_cc),
    .any_busy (b_any_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_wr_en = 0; a_wr_cc_en = 0; a_iss_en = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      a_wr_en    = 1;
      a_wr_addr  = 3'($urandom_range(0, 7));
      a_wr_data  = 16'($urandom) | 16'h0001;
      a_wr_cc_en = 1;
      a_iss_en   = 1;
      a_iss_addr = 3'($urandom_range(0, 7));
      tick();
    end
    reset_ = 0;
    tick();
    reset_ = 1;
    idle_a();
    for (int a = 0; a < 8; a++) begin
      a_rd_addr = {3'(a), 3'(a)};
      #1;
      checks++;
      if (a_rd_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd_data addr=%0d got=%h exp=%h", a, a_rd_data, 32'h0);
      end
      checks++;
      if (a_rd_busy !== 2'b00) begin
        failures++;
        $display("FAIL reset_rd_busy addr=%0d got=%b exp=%b", a, a_rd_busy, 2'b00);
      end
    end
    checks++;
    if (a_cc !== 3'b010) begin
      failures++;
      $display("FAIL reset_cc got=%b exp=%b", a_cc, 3'b010);
    end
    checks++;
    if (a_any_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_any_busy got=%b exp=%b", a_any_busy, 1'b0);
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_write_read();
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 16'hBEEF;
    tick();
    idle_a();
    a_rd_addr = {3'd3, 3'd3};
    #1;
    checks++;
    if (a_rd_data[15:0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_rd_port0 got=%h exp=%h", a_rd_data[15:0], 16'hBEEF);
    end
    checks++;
    if (a_rd_data[31:16] !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_rd_port1 got=%h exp=%h", a_rd_data[31:16], 16'hBEEF);
    end
    a_rd_addr = {3'd2, 3'd3};
    #1;
    checks++;
    if (a_rd_data !== {16'h0000, 16'hBEEF}) begin
      failures++;
      $display("FAIL wr_rd_r2_zero got=%h exp=%h", a_rd_data, {16'h0000, 16'hBEEF});
    end
    $display("test_write_read done checks=%0d", checks);
  endtask

  task automatic test_cc();
    logic [15:0] data_v [4] = '{16'h8000, 16'h0000, 16'h0001, 16'h8000};
    logic        en_v   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  exp_v  [4] = '{3'b100, 3'b010, 3'b001, 3'b001};
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_addr = 1; a_wr_data = data_v[i]; a_wr_cc_en = en_v[i];
      tick();
      idle_a();
      #1;
      checks++;
      if (a_cc !== exp_v[i]) begin
        failures++;
        $display("FAIL cc_step%0d data=%h got=%b exp=%b", i, data_v[i], a_cc, exp_v[i]);
      end
    end
    a_wr_en = 0; a_wr_cc_en = 1; a_wr_data = 16'h0000;
    tick();
    idle_a();
    checks++;
    if (a_cc !== 3'b001) begin
      failures++;
      $display("FAIL cc_no_wr_en got=%b exp=%b", a_cc, 3'b001);
    end
    $display("test_cc done checks=%0d", checks);
  endtask

  task automatic test_scoreboard();
    a_iss_en = 1; a_iss_addr = 5;
    tick();
    idle_a();
    a_rd_addr = {3'd5, 3'd5};
    #1;
    checks++;
    if (a_rd_busy !== 2'b11 || a_any_busy !== 1'b1) begin
      failures++;
      $display("FAIL sb_issue got=%b/%b exp=11/1", a_rd_busy, a_any_busy);
    end
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 16'h0055;
    tick();
    idle_a();
    checks++;
    if (a_rd_busy !== 2'b00 || a_any_busy !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear got=%b/%b exp=00/0", a_rd_busy, a_any_busy);
    end
    a_iss_en = 1; a_iss_addr = 5; a_wr_en = 1; a_wr_addr = 5; a_wr_data = 16'h0056;
    tick();
    idle_a();
    checks++;
    if (a_rd_busy !== 2'b11) begin
      failures++;
      $display("FAIL sb_set_wins got=%b exp=%b", a_rd_busy, 2'b11);
    end
    a_iss_en = 1; a_iss_addr = 1; a_wr_en = 1; a_wr_addr = 5; a_wr_data = 16'h0057;
    tick();
    idle_a();
    a_rd_addr = {3'd5, 3'd1};
    #1;
    checks++;
    if (a_rd_busy !== 2'b01 || a_any_busy !== 1'b1) begin
      failures++;
      $display("FAIL sb_split got=%b/%b exp=01/1", a_rd_busy, a_any_busy);
    end
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 16'h0011;
    tick();
    idle_a();
    checks++;
    if (a_any_busy !== 1'b0) begin
      failures++;
      $display("FAIL sb_drain got=%b exp=%b", a_any_busy, 1'b0);
    end
    $display("test_scoreboard done checks=%0d", checks);
  endtask

  task automatic test_bypass();
    logic [15:0] exp_d;
    a_rd_addr = {3'd0, 3'd4};
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 16'h1234;
    #1;
    exp_d = BYPASS ? 16'h1234 : 16'h0000;
    checks++;
    if (a_rd_data[15:0] !== exp_d || a_rd_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h/%b exp=%h/0", a_rd_data[15:0], a_rd_busy[0], exp_d);
    end
    tick();
    idle_a();
    checks++;
    if (a_rd_data[15:0] !== 16'h1234) begin
      failures++;
      $display("FAIL bypass_next_cycle got=%h exp=%h", a_rd_data[15:0], 16'h1234);
    end
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 16'h4321; a_iss_en = 1; a_iss_addr = 4;
    #1;
    checks++;
    if (a_rd_busy[0] !== BYPASS) begin
      failures++;
      $display("FAIL bypass_iss_busy got=%b exp=%b", a_rd_busy[0], BYPASS);
    end
    tick();
    idle_a();
    checks++;
    if (a_rd_busy[0] !== 1'b1 || a_rd_data[15:0] !== 16'h4321) begin
      failures++;
      $display("FAIL bypass_iss_after got=%b/%h exp=1/4321", a_rd_busy[0], a_rd_data[15:0]);
    end
    $display("test_bypass done checks=%0d", checks);
  endtask

  task automatic test_depth6();
    b_wr_en = 1; b_wr_addr = 7; b_wr_data = 16'hFFFF; b_iss_en = 1; b_iss_addr = 7;
    tick();
    b_wr_en = 1; b_wr_addr = 6; b_wr_data = 16'hEEEE; b_iss_en = 1; b_iss_addr = 6;
    tick();
    b_wr_en = 0; b_iss_en = 0;
    b_rd_addr = {3'd0, 3'd7, 3'd6};
    #1;
    checks++;
    if (b_rd_data !== 48'h0 || b_rd_busy !== 3'b000 || b_any_busy !== 1'b0) begin
      failures++;
      $display("FAIL d6_out_of_range got=%h/%b/%b exp=0/000/0", b_rd_data, b_rd_busy, b_any_busy);
    end
    b_wr_en = 1; b_wr_addr = 5; b_wr_data = 16'hAAAA;
    tick();
    b_wr_addr = 0; b_wr_data = 16'h1111;
    tick();
    b_wr_addr = 2; b_wr_data = 16'h2222;
    tick();
    b_wr_en = 0;
    b_rd_addr = {3'd2, 3'd0, 3'd5};
    #1;
    checks++;
    if (b_rd_data !== {16'h2222, 16'h1111, 16'hAAAA}) begin
      failures++;
      $display("FAIL d6_three_ports got=%h exp=%h", b_rd_data, {16'h2222, 16'h1111, 16'hAAAA});
    end
    b_rd_addr = {3'd5, 3'd6, 3'd2};
    #1;
    checks++;
    if (b_rd_data !== {16'hAAAA, 16'h0000, 16'h2222}) begin
      failures++;
      $display("FAIL d6_mixed got=%h exp=%h", b_rd_data, {16'hAAAA, 16'h0000, 16'h2222});
    end
    $display("test_depth6 done checks=%0d", checks);
  endtask

  initial begin
    reset_ = 0;
    idle_a();
    a_wr_addr = 0; a_wr_data = 0; a_iss_addr = 0; a_rd_addr = 0;
    b_wr_en = 0; b_wr_cc_en = 0; b_iss_en = 0;
    b_wr_addr = 0; b_wr_data = 0; b_iss_addr = 0; b_rd_addr = 0;
    tick();
    tick();
    reset_ = 1;
    tick();
    test_reset();
    test_write_read();
    test_cc();
    test_scoreboard();
    test_bypass();
    test_depth6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
